instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
Parametrised instruction prefetch buffer between instruction memory and the core's decode stage. It replaces per-cycle hand-driven instruction words with an autonomous fetch engine. The engine issues sequential word fetches, buffers returned instructions with their PC, and presents them to the core over a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight memory responses.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, queue entries (power of two, >=2)
MAX_INFLIGHT, 2, maximum outstanding memory requests (>=1)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_addr  out  XLEN  fetch byte address, bits[1:0]=0
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  instruction word returned, in request order
mem_resp_data  in  32  returned instruction word
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  XLEN  new fetch target
inst_valid  out  1  queue head holds an instruction
inst  out  32  head instruction word
inst_pc  out  XLEN  PC of head instruction
inst_ready  in  1  core consumes head this cycle
occupancy  out  $clog2(DEPTH)+1  entries currently queued
resp_err  out  1  sticky: response received with nothing in flight

Behaviour:
- Reset (rst=1 at clock edge): fetch_pc=resp_pc=RESET_PC, inflight=0, drop_cnt=0, queue empty, resp_err=0. mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, occupancy=0. Reset mid-burst abandons all state. Responses arriving in the first cycle after reset are treated as unexpected.
- Credit: live = inflight - drop_cnt. mem_req_valid = !rst && !redirect_valid && (occupancy + live < DEPTH) && (inflight < MAX_INFLIGHT). mem_req_addr = fetch_pc.
- Issue: mem_req_valid && mem_req_ready -> fetch_pc += 4 (wraps modulo 2^XLEN), inflight+1.
- Response: mem_resp_valid decrements inflight.
  - If drop_cnt>0: decrement drop_cnt and discard the word.
  - Otherwise: push {resp_pc, mem_resp_data} and set resp_pc += 4.
  - Overflow is impossible by credit. Verification asserts it never occurs.
- Response with inflight=0: ignored and sets resp_err. resp_err clears only on rst.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle leaves occupancy unchanged. A push to an empty queue is visible on inst_valid the next cycle (1-cycle response-to-output latency).
- Redirect has top priority:
  - Queue flushed; any same-cycle pop is ignored.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt = inflight - mem_resp_valid; a same-cycle response is discarded.
  - inflight = inflight - mem_resp_valid.
  - No request is issued in the redirect cycle.
  - inst_valid=0 the following cycle.
- Back-to-back redirects: each recomputes drop_cnt from the current inflight. The last one wins.
- Fetch control states, encoded from counters:
  - FILL: credit available.
  - HOLD: queue + live requests at DEPTH, or inflight at MAX.
  - DRAIN: drop_cnt>0; requests are allowed if credit permits.
- inst/inst_pc hold the head value while !inst_ready. They read 0 when empty.

Decomposition:
- Package fetch_pkg: XLEN default, ILEN=32, INST_BYTES=4, NOP=32'h0000_0013, and a typedef struct {pc, word} fetch_entry_t.
- One sub-module: sync_fifo, parametrised on width/depth, with sync active-high reset and flush. It holds fetch_entry_t entries.
- Credit, drop and PC logic live in the top.

Test Plan:
1. Reset, inst_ready=1, memory always ready with 1-cycle response -> requests at 0,4,8,...; inst sequence 3e800093,83000113,3e906193 with inst_pc 0,4,8; no bubbles after first fill.
2. inst_ready=0 with DEPTH=4 -> exactly 4 entries queued and occupancy=4. mem_req_valid deasserts while occupancy+live=4, and no word is lost once inst_ready=1.
3. Two requests in flight; redirect_pc=0x3E8 -> both late responses dropped; next inst_pc=0x3E8, then 0x3EC; occupancy 0 the cycle after redirect.
4. Redirect with simultaneous mem_resp_valid and inst_ready -> neither pushed nor popped. Redirect with redirect_pc=0x3EB -> fetch at 0x3E8.
5. fetch_pc=0xFFFF_FFFC, sequential fetch -> next request addr 0x0000_0000; inst_pc wraps correspondingly.
6. mem_resp_valid pulsed after reset with nothing requested -> resp_err=1, queue stays empty. Assert rst mid-burst -> all outputs at reset values next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// The queue entry pairs each instruction word with the PC it was fetched from.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  // Fetch control condition, decoded from the credit and drop counters
  typedef enum logic [1:0] {
    FETCH_FILL  = 2'd0,
    FETCH_HOLD  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with active-high reset and single-cycle flush.
// Storage is registered, so a pushed entry appears at dout one cycle later.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Autonomous sequential instruction fetcher with a small prefetch queue.
// Redirects flush the queue and count off stale in-flight responses to discard.
module instr_prefetch_queue #(
  parameter int              XLEN         = fetch_pkg::XLEN,
  parameter int              DEPTH        = 4,
  parameter int              MAX_INFLIGHT = 2,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_valid,
  output logic [XLEN-1:0]          mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [XLEN-1:0]          inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     resp_err
);

  import fetch_pkg::*;

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = OW + IW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [IW-1:0]   inflight;
  logic [IW-1:0]   drop_cnt;
  logic [IW-1:0]   live;
  logic            credit_ok;
  logic            req_en;
  logic            issue;
  logic            resp_ok;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [$bits(fetch_entry_t)-1:0] head_bits;
  fetch_state_e    fetch_state;

  assign live      = inflight - drop_cnt;
  assign credit_ok = ((SW'(occupancy) + SW'(live)) < SW'(DEPTH)) &&
                     (inflight < IW'(MAX_INFLIGHT));

  always_comb begin
    fetch_state = FETCH_FILL;
    if (drop_cnt != '0)  fetch_state = FETCH_DRAIN;
    else if (!credit_ok) fetch_state = FETCH_HOLD;
  end

  // Draining stale responses does not block new requests when credit remains
  assign req_en        = (fetch_state == FETCH_FILL) ||
                         ((fetch_state == FETCH_DRAIN) && credit_ok);
  assign mem_req_valid = !rst && !redirect_valid && req_en;
  assign mem_req_addr  = fetch_pc;
  assign issue         = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is flagged and otherwise ignored
  assign resp_ok   = mem_resp_valid && (inflight != '0);
  assign resp_drop = resp_ok && (redirect_valid || (drop_cnt != '0));
  assign push      = resp_ok && !resp_drop;
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  assign redirect_target = redirect_pc & ~XLEN'(INST_BYTES - 1);

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = resp_pc;
    push_entry.word = mem_resp_data;
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_bits),
    .count (occupancy),
    .empty (fifo_empty)
  );

  assign head_entry = fetch_entry_t'(head_bits);
  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head_entry.word : '0;
  assign inst_pc    = inst_valid ? head_entry.pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        inflight <= inflight - IW'(resp_ok);
        drop_cnt <= inflight - IW'(resp_ok);
      end else begin
        if (issue) fetch_pc <= fetch_pc + STEP;
        inflight <= inflight + IW'(issue) - IW'(resp_ok);
        if (resp_ok) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - IW'(1);
          else                resp_pc  <= resp_pc + STEP;
        end
      end
      if (mem_resp_valid && (inflight == '0)) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised bench for instr_prefetch_queue against a sequence-level model:
// the model tracks outstanding requests (old path or current path), queue fill and the next expected PC.
module tb_instr_prefetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          MAXI   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  occupancy;
  logic        resp_err;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .occupancy(occupancy), .resp_err(resp_err)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          occ;
  bit          err;
  int          total = 0;
  int          bad = 0;

  bit          d_rst, d_mrdy, d_resp, d_bogus, d_redir, d_irdy;
  logic [31:0] d_rpc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3e80_0093;
      32'h4:   return 32'h8300_0113;
      32'h8:   return 32'h3e90_6193;
      default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic tick();
    int    live;
    bit    want_req, good;
    pend_t e;
    @(negedge clk);
    rst            = d_rst;
    mem_req_ready  = d_mrdy;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    inst_ready     = d_irdy;
    mem_resp_valid = (d_resp && pend.size() > 0) || d_bogus;
    mem_resp_data  = (pend.size() > 0) ? word_at(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    want_req = !d_rst && !d_redir && (occ + live < DEPTH) && (pend.size() < MAXI);
    chk("req_valid", mem_req_valid, want_req);
    chk("req_addr", mem_req_addr, exp_req);
    chk("inst_valid", inst_valid, occ > 0);
    chk("inst", inst, (occ > 0) ? word_at(exp_pc) : 32'h0);
    chk("inst_pc", inst_pc, (occ > 0) ? exp_pc : 32'h0);
    chk("occupancy", occupancy, occ);
    chk("resp_err", resp_err, err);
    if (d_rst) begin
      pend.delete();
      occ = 0; err = 0;
      exp_pc = RST_PC; exp_req = RST_PC;
    end else begin
      good = 0;
      if (mem_resp_valid) begin
        if (pend.size() == 0) err = 1;
        else begin
          e = pend.pop_front();
          good = !e.stale && !d_redir;
        end
      end
      if (d_redir) begin
        occ = 0;
        foreach (pend[i]) pend[i].stale = 1;
        exp_pc  = d_rpc & 32'hFFFF_FFFC;
        exp_req = exp_pc;
      end else begin
        if (occ > 0 && d_irdy) begin occ--; exp_pc += 4; end
        if (good) occ++;
        if (want_req && d_mrdy) begin
          pend.push_back('{addr: exp_req, stale: 1'b0});
          exp_req += 4;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit mr, input bit rv, input bit rd,
                       input logic [31:0] rp, input bit ir);
    d_rst = r; d_mrdy = mr; d_resp = rv; d_redir = rd; d_rpc = rp; d_irdy = ir; d_bogus = 0;
  endtask

  initial begin
    rst = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    repeat (2) @(posedge clk);

    // reset state, then steady sequential fetch with a 1-cycle memory
    drive(1, 1, 1, 0, 0, 1); tick();
    drive(0, 1, 1, 0, 0, 1); repeat (12) tick();

    // stall the core: queue fills exactly to DEPTH and requests stop
    drive(0, 1, 1, 0, 0, 0); repeat (10) tick();
    chk("occ_full", occupancy, 4);
    chk("hold_req", mem_req_valid, 0);
    drive(0, 1, 1, 0, 0, 1); repeat (8) tick();

    // two requests outstanding, then redirect; old responses must vanish
    drive(1, 1, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 0); repeat (3) tick();
    drive(0, 1, 0, 1, 32'h3E8, 0); tick();
    drive(0, 1, 1, 0, 0, 0); repeat (6) tick();
    chk("redir_head", inst_pc, 32'h3E8);
    drive(0, 1, 1, 0, 0, 1); repeat (4) tick();

    // redirect colliding with a response and a pop; unaligned target
    drive(0, 1, 1, 1, 32'h3EB, 1); tick();
    drive(0, 1, 1, 0, 0, 0); tick();
    chk("redir_flush", occupancy, 0);
    repeat (5) tick();
    chk("align_head", inst_pc, 32'h3E8);

    // fetch address wraps at the top of the address space
    drive(0, 1, 1, 1, 32'hFFFF_FFF8, 1); tick();
    drive(0, 1, 1, 0, 0, 1); repeat (10) tick();

    // unexpected response right after reset
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); d_bogus = 1; tick();
    d_bogus = 0; tick();
    chk("resp_err_set", resp_err, 1);
    chk("err_empty", inst_valid, 0);

    // reset in the middle of a burst
    drive(0, 1, 1, 0, 0, 1); repeat (6) tick();
    drive(1, 1, 1, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("rst_addr", mem_req_addr, RST_PC);
    chk("rst_err", resp_err, 0);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      d_rst   = ($urandom_range(0, 99) == 0);
      d_mrdy  = ($urandom_range(0, 3) != 0);
      d_resp  = ($urandom_range(0, 2) != 0);
      d_irdy  = ($urandom_range(0, 2) != 0);
      d_redir = ($urandom_range(0, 19) == 0);
      d_rpc   = $urandom;
      d_bogus = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
